// File: rtl/bluetooth_recv_ctrl.sv
// rtl/bluetooth_recv_ctrl.sv - UART frame receiver: checks header/length/checksum,
// buffers the payload and writes only verified frames into the RX FIFO.
module bluetooth_recv_ctrl #(
   parameter int         MAX_LEN     = 16,
   parameter logic [7:0] HEADER      = 8'hA5,
   parameter int         TIMEOUT_CYC = 50000
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       uart_rx_done,
   input  logic [7:0] uart_rx_data,
   input  logic       fifo_full,
   output logic       fifo_wr_req,
   output logic [7:0] fifo_wr_data,
   output logic       frame_ok,
   output logic       frame_err,
   output logic       rx_overrun,
   output logic       busy
);

   localparam int              IW       = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam int              TW       = $clog2(TIMEOUT_CYC);
   localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT_CYC - 1);
   localparam logic [7:0]      LEN_MAX  = 8'(MAX_LEN);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEN,
      S_DATA,
      S_CHK,
      S_PUSH
   } state_t;

   state_t        state_q;
   logic [7:0]    len_q;
   logic [7:0]    idx_q;
   logic [7:0]    acc_q;
   logic [TW-1:0] tmo_q;
   logic          fifo_wr_req_q;
   logic [7:0]    fifo_wr_data_q;
   logic          frame_ok_q;
   logic          frame_err_q;
   logic          rx_overrun_q;
   logic [7:0]    buf_q [MAX_LEN];

   logic          in_frame;

   assign in_frame = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_CHK);

   // Payload storage is deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (state_q == S_DATA && uart_rx_done) begin
         buf_q[idx_q[IW-1:0]] <= uart_rx_data;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q        <= S_IDLE;
         len_q          <= 8'h00;
         idx_q          <= 8'h00;
         acc_q          <= 8'h00;
         tmo_q          <= '0;
         fifo_wr_req_q  <= 1'b0;
         fifo_wr_data_q <= 8'h00;
         frame_ok_q     <= 1'b0;
         frame_err_q    <= 1'b0;
         rx_overrun_q   <= 1'b0;
      end else begin
         fifo_wr_req_q <= 1'b0;
         frame_ok_q    <= 1'b0;
         frame_err_q   <= 1'b0;
         rx_overrun_q  <= 1'b0;

         case (state_q)
            S_IDLE: begin
               if (uart_rx_done && uart_rx_data == HEADER) begin
                  state_q <= S_LEN;
                  tmo_q   <= '0;
               end
            end
            S_LEN: begin
               if (uart_rx_done) begin
                  if (uart_rx_data != 8'h00 && uart_rx_data <= LEN_MAX) begin
                     len_q   <= uart_rx_data;
                     acc_q   <= uart_rx_data;
                     idx_q   <= 8'h00;
                     state_q <= S_DATA;
                  end else begin
                     frame_err_q <= 1'b1;
                     state_q     <= S_IDLE;
                  end
               end
            end
            S_DATA: begin
               if (uart_rx_done) begin
                  acc_q <= acc_q + uart_rx_data;
                  idx_q <= idx_q + 8'd1;
                  if (idx_q + 8'd1 == len_q) begin
                     state_q <= S_CHK;
                  end
               end
            end
            S_CHK: begin
               if (uart_rx_done) begin
                  if (uart_rx_data == acc_q) begin
                     idx_q   <= 8'h00;
                     state_q <= S_PUSH;
                  end else begin
                     frame_err_q <= 1'b1;
                     state_q     <= S_IDLE;
                  end
               end
            end
            S_PUSH: begin
               rx_overrun_q <= uart_rx_done;
               // A strobe cycle always follows with a gap, so fifo_full is fresh for the next write.
               if (fifo_wr_req_q) begin
                  if (idx_q == len_q) begin
                     frame_ok_q <= 1'b1;
                     state_q    <= S_IDLE;
                  end
               end else if (!fifo_full) begin
                  fifo_wr_req_q  <= 1'b1;
                  fifo_wr_data_q <= buf_q[idx_q[IW-1:0]];
                  idx_q          <= idx_q + 8'd1;
               end
            end
            default: state_q <= S_IDLE;
         endcase

         // A byte arriving on the timeout edge wins over the timeout.
         if (in_frame) begin
            if (uart_rx_done) begin
               tmo_q <= '0;
            end else if (tmo_q == TMO_LAST) begin
               tmo_q       <= '0;
               frame_err_q <= 1'b1;
               state_q     <= S_IDLE;
            end else begin
               tmo_q <= tmo_q + TW'(1);
            end
         end
      end
   end

   assign fifo_wr_req  = fifo_wr_req_q;
   assign fifo_wr_data = fifo_wr_data_q;
   assign frame_ok     = frame_ok_q;
   assign frame_err    = frame_err_q;
   assign rx_overrun   = rx_overrun_q;
   assign busy         = (state_q != S_IDLE);

endmodule

// File: doc/bluetooth_recv_ctrl.md
# bluetooth_recv_ctrl

Receive-side controller for the Bluetooth UART link: takes bytes from the UART receiver, recognises framed packets (header, length, payload, checksum), buffers the payload internally, and writes only checksum-verified payload bytes into the downstream RX FIFO. It is the counterpart of the send controller, which drains the TX FIFO into the UART transmitter. Malformed, truncated or corrupted frames are discarded whole and flagged.

## Interface
- `MAX_LEN`, 16: maximum payload length in bytes; range 1..255.
- `HEADER`, 8'hA5: frame start byte.
- `TIMEOUT_CYC`, 50000: inter-byte timeout in clk cycles; must be ≥ 2.

- `clk` in 1: single clock; all logic is rising-edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `uart_rx_done` in 1: one-cycle pulse; `uart_rx_data` is valid in that cycle.
- `uart_rx_data` in 8: received byte.
- `fifo_full` in 1: RX FIFO full flag.
- `fifo_wr_req` out 1: one-cycle write strobe to the RX FIFO.
- `fifo_wr_data` out 8: write data; valid while `fifo_wr_req`=1.
- `frame_ok` out 1: one-cycle pulse when a good frame has been fully written.
- `frame_err` out 1: one-cycle pulse when a frame is discarded.
- `rx_overrun` out 1: one-cycle pulse when a byte arrives during PUSH and is dropped.
- `busy` out 1: high whenever state ≠ IDLE.

## Operation
- Frame format: `HEADER`, `LEN`, `LEN` payload bytes, `CHK`.
- `CHK` = (`LEN` + sum of payload bytes) mod 256, computed in an 8-bit accumulator.
- States and transitions on `uart_rx_done`:
  - IDLE: if the byte is `HEADER`, go to LEN. Other bytes are ignored, with no flag.
  - LEN: if 1 ≤ byte ≤ `MAX_LEN`, latch the length, set acc = byte, clear the index, and go to DATA. Otherwise pulse `frame_err` and go to IDLE. `LEN` = `HEADER` gets no special case.
  - DATA: write the byte to `buf[idx]`, add it to acc, and increment idx. When idx reaches `LEN`, go to CHK.
  - CHK: if byte = acc, go to PUSH with idx cleared. Otherwise pulse `frame_err` and go to IDLE.
  - PUSH: no rx bytes are accepted. Each `uart_rx_done` pulses `rx_overrun`, and the byte is dropped. When `fifo_full`=0 and `fifo_wr_req`=0, register `fifo_wr_req`=1 with `fifo_wr_data`=`buf[idx]`, then increment idx. After the last byte's strobe, pulse `frame_ok` in the next cycle and go to IDLE.
- Writes are at most one per two cycles, so the FIFO's registered full flag is always current when the next write is decided. `fifo_full` held high stalls PUSH indefinitely; there is no timeout in PUSH.
- Timeout applies only in LEN, DATA and CHK:
  - The counter clears on every `uart_rx_done` and on entry to LEN.
  - It otherwise increments each cycle.
  - At `TIMEOUT_CYC`-1 it pulses `frame_err` and forces IDLE.
  - If `uart_rx_done` and timeout occur in the same cycle, the byte wins and no error is raised.
- The buffer is a `MAX_LEN`×8 register array. Its contents are not reset; only state, counters and outputs are.

## Timing
- Reset values:
  - `fifo_wr_req`, `frame_ok`, `frame_err`, `rx_overrun` = 0.
  - `fifo_wr_data` = 8'h00.
  - `busy` = 0; state = IDLE; idx, acc, length and timeout counter = 0.
- All outputs are registered except `busy`, which is decoded from the state register.
- Good frame with `LEN`=N, CHK accepted at edge T, FIFO never full:
  - `fifo_wr_req` is high in cycles T+2, T+4, …, T+2N.
  - `frame_ok` is high in cycle T+2N+1, and `busy` falls in the same cycle.
- `frame_err` is asserted in the cycle after the offending byte or the timeout edge, with state already IDLE.
- Reset asserted mid-frame or mid-PUSH aborts immediately. No further `fifo_wr_req` occurs and no flag pulses.

## Test plan
- Good frame: A5 03 11 22 33 69 → writes 11, 22, 33 on alternate cycles. One `frame_ok`, no `frame_err`.
- Bad checksum: A5 02 10 20 31 → no `fifo_wr_req`, one `frame_err`. The following A5 01 7E 7F is then written as 7E with `frame_ok`.
- Length bounds, one case each:
  - A5 00 → `frame_err`.
  - A5 11 with `MAX_LEN`=16 → `frame_err`.
  - A5 10 plus 16 bytes and the correct CHK → 16 writes.
- Timeout: A5 02 AA, then idle `TIMEOUT_CYC` cycles → `frame_err` exactly once, `busy`=0. Garbage bytes 00 FF 5A before A5 are ignored silently.
- FIFO stall: hold `fifo_full`=1 during PUSH of a 3-byte frame for 100 cycles → no writes and `busy`=1. Release → 3 writes, then `frame_ok`. A byte sent during PUSH → `rx_overrun` pulse and the byte is not written.
- Reset mid-PUSH: assert `reset_n`=0 after the first write → all outputs 0 immediately. After release, a new good frame is processed normally.
